// File: rtl/pll_reset_sequencer.sv
// Reset sequencer behind the board PLL: retries the PLL until it holds lock, then releases
// the SDRAM controller and the Nios II system in order, and re-sequences on any loss of lock.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned SDRAM_HOLD_CYCLES   = 10000,
    parameter int unsigned SYS_DELAY_CYCLES    = 256,
    parameter int unsigned CNT_W               = 17,
    parameter int unsigned RETRY_W             = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sdram_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_count,
    output logic [RETRY_W-1:0] lost_lock_count
);

    typedef enum logic [2:0] {
        S_PLL_RST    = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_SDRAM_HOLD = 3'd3,
        S_SYS_WAIT   = 3'd4,
        S_RUN        = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LD_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(SDRAM_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_SYS     = CNT_W'(SYS_DELAY_CYCLES - 1);

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [RETRY_W-1:0] retry_d;
    logic [RETRY_W-1:0] lost_d;
    logic               sync1;
    logic               sync2;
    logic               lk;
    logic               cnt_zero;
    logic               pll_rst_d;
    logic               sdram_rst_d;
    logic               sys_rst_d;
    logic               ready_d;

    // Two-flop synchronizer for the asynchronous lock indicator
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            sync2 <= sync1;
        end
    end

    assign lk       = sync2;
    assign cnt_zero = (cnt == '0);

    // State register, shared down-counter and event counters
    always_ff @(posedge refclk) begin
        if (rst) begin
            state           <= S_PLL_RST;
            cnt             <= LD_PLL_RST;
            retry_count     <= '0;
            lost_lock_count <= '0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            retry_count     <= retry_d;
            lost_lock_count <= lost_d;
        end
    end

    // Next-state logic; lock loss takes priority over counter expiry
    always_comb begin
        state_d = state;
        cnt_d   = cnt_zero ? cnt : cnt - CNT_W'(1);
        retry_d = retry_count;
        lost_d  = lost_lock_count;
        case (state)
            S_PLL_RST: begin
                if (cnt_zero) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = LD_TIMEOUT;
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                    cnt_d   = LD_STABLE;
                end else if (cnt_zero) begin
                    state_d = S_PLL_RST;
                    cnt_d   = LD_PLL_RST;
                    retry_d = (retry_count == '1) ? retry_count : retry_count + RETRY_W'(1);
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = LD_TIMEOUT;
                end else if (cnt_zero) begin
                    state_d = S_SDRAM_HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            S_SDRAM_HOLD, S_SYS_WAIT, S_RUN: begin
                if (!lk) begin
                    state_d = S_PLL_RST;
                    cnt_d   = LD_PLL_RST;
                    lost_d  = (lost_lock_count == '1) ? lost_lock_count
                                                      : lost_lock_count + RETRY_W'(1);
                end else if (cnt_zero && state == S_SDRAM_HOLD) begin
                    state_d = S_SYS_WAIT;
                    cnt_d   = LD_SYS;
                end else if (cnt_zero && state == S_SYS_WAIT) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = LD_PLL_RST;
            end
        endcase
    end

    // Output decode of the upcoming state, so the registered levels track the state register
    always_comb begin
        pll_rst_d   = 1'b1;
        sdram_rst_d = 1'b1;
        sys_rst_d   = 1'b1;
        ready_d     = 1'b0;
        case (state_d)
            S_WAIT_LOCK, S_STABLE, S_SDRAM_HOLD: begin
                pll_rst_d = 1'b0;
            end
            S_SYS_WAIT: begin
                pll_rst_d   = 1'b0;
                sdram_rst_d = 1'b0;
            end
            S_RUN: begin
                pll_rst_d   = 1'b0;
                sdram_rst_d = 1'b0;
                sys_rst_d   = 1'b0;
                ready_d     = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst   <= 1'b1;
            sdram_rst <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            pll_rst   <= pll_rst_d;
            sdram_rst <= sdram_rst_d;
            sys_rst   <= sys_rst_d;
            ready     <= ready_d;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/age reference model checked every cycle, plus
// hand-computed cycle-exact expectations for the directed scenarios.
module tb_pll_reset_sequencer;

    localparam int unsigned P_PLL   = 4;
    localparam int unsigned P_STAB  = 8;
    localparam int unsigned P_TO    = 32;
    localparam int unsigned P_HOLD  = 16;
    localparam int unsigned P_SYS   = 8;
    localparam int          SAT     = 15;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sdram_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retry_count;
    logic [3:0] lost_lock_count;

    int total = 0;
    int bad = 0;
    int t = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (P_PLL),
        .LOCK_STABLE_CYCLES (P_STAB),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .SDRAM_HOLD_CYCLES  (P_HOLD),
        .SYS_DELAY_CYCLES   (P_SYS),
        .CNT_W              (17),
        .RETRY_W            (4)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .pll_rst        (pll_rst),
        .sdram_rst      (sdram_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .retry_count    (retry_count),
        .lost_lock_count(lost_lock_count)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0d, time %0t)", name, act, exp, t, $time);
        end
    endtask

    // Reference model: phases 0..5 = pll reset, wait lock, stable, sdram hold, sys wait, run.
    // m_age counts cycles already spent in the phase; a timed phase of N cycles exits at age N-1.
    int  dur [6] = '{int'(P_PLL), int'(P_TO), int'(P_STAB), int'(P_HOLD), int'(P_SYS), 0};
    int  m_phase = 0;
    int  m_next = 0;
    int  m_age = 0;
    int  m_retry = 0;
    int  m_lost = 0;
    bit  m_h1 = 1'b0;
    bit  m_h2 = 1'b0;
    bit  m_lk = 1'b0;
    bit  m_valid = 1'b0;

    always @(posedge refclk) begin
        if (rst) begin
            m_phase = 0; m_age = 0; m_retry = 0; m_lost = 0;
            m_h1 = 1'b0; m_h2 = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_lk = m_h2;
            m_h2 = m_h1;
            m_h1 = pll_locked;
            m_next = m_phase;
            if (m_phase >= 3 && !m_lk) begin
                m_lost = (m_lost < SAT) ? m_lost + 1 : SAT;
                m_next = 0;
            end else if (m_phase == 2 && !m_lk) begin
                m_next = 1;
            end else if (m_phase == 1 && m_lk) begin
                m_next = 2;
            end else if (m_phase < 5 && m_age == dur[m_phase] - 1) begin
                if (m_phase == 1) begin
                    m_retry = (m_retry < SAT) ? m_retry + 1 : SAT;
                    m_next = 0;
                end else begin
                    m_next = m_phase + 1;
                end
            end
            if (m_next != m_phase) m_age = 0;
            else m_age++;
            m_phase = m_next;
        end
    end

    // Every-cycle compare against the model plus the ordering invariants
    always @(negedge refclk) begin
        if (m_valid) begin
            chk("model_pll_rst",   32'(pll_rst),   32'(m_phase == 0));
            chk("model_sdram_rst", 32'(sdram_rst), 32'(m_phase <= 3));
            chk("model_sys_rst",   32'(sys_rst),   32'(m_phase != 5));
            chk("model_ready",     32'(ready),     32'(m_phase == 5));
            chk("model_retry",     32'(retry_count),     32'(m_retry));
            chk("model_lost",      32'(lost_lock_count), 32'(m_lost));
            chk("inv_sys_sdram",   32'(!sys_rst && sdram_rst), 32'(0));
            chk("inv_sdram_pll",   32'(!sdram_rst && pll_rst), 32'(0));
            chk("inv_ready",       32'(ready), 32'(!sys_rst));
        end
    end

    task automatic step();
        @(posedge refclk);
        #1;
        t++;
    endtask

    task automatic step_to(input int target);
        while (t < target) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
        t = 0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_rst"},   32'(pll_rst),   32'(1));
        chk({tag, "_sdram_rst"}, 32'(sdram_rst), 32'(1));
        chk({tag, "_sys_rst"},   32'(sys_rst),   32'(1));
        chk({tag, "_ready"},     32'(ready),     32'(0));
        chk({tag, "_retry"},     32'(retry_count),     32'(0));
        chk({tag, "_lost"},      32'(lost_lock_count), 32'(0));
    endtask

    int seg;

    initial begin
        // Clean bring-up, then lock loss in RUN
        pll_locked = 1'b0;
        do_reset(3);
        chk_reset_values("rst");
        step_to(3);  chk("s1_pll_high_t3", 32'(pll_rst), 32'(1));
        step_to(4);  chk("s1_pll_fall_t4", 32'(pll_rst), 32'(0));
        step_to(8);  pll_locked = 1'b1;
        step_to(34); chk("s1_sdram_t34", 32'(sdram_rst), 32'(1));
        step_to(35); chk("s1_sdram_t35", 32'(sdram_rst), 32'(0));
        step_to(42); chk("s1_sys_t42", 32'(sys_rst), 32'(1));
        chk("s1_ready_t42", 32'(ready), 32'(0));
        step_to(43); chk("s1_sys_t43", 32'(sys_rst), 32'(0));
        chk("s1_ready_t43", 32'(ready), 32'(1));
        chk("s1_counts", 32'({retry_count, lost_lock_count}), 32'(0));

        step_to(49); pll_locked = 1'b0;
        step_to(50); pll_locked = 1'b1;
        step_to(51); chk("s4_ready_t51", 32'(ready), 32'(1));
        step_to(52); chk("s4_ready_t52", 32'(ready), 32'(0));
        chk("s4_sys_t52",   32'(sys_rst),   32'(1));
        chk("s4_sdram_t52", 32'(sdram_rst), 32'(1));
        chk("s4_pll_t52",   32'(pll_rst),   32'(1));
        chk("s4_lost_t52",  32'(lost_lock_count), 32'(1));
        step_to(55); chk("s4_pll_t55", 32'(pll_rst), 32'(1));
        step_to(56); chk("s4_pll_t56", 32'(pll_rst), 32'(0));
        step_to(88); chk("s4_ready_t88", 32'(ready), 32'(0));
        step_to(89); chk("s4_ready_t89", 32'(ready), 32'(1));
        step_to(90); pll_locked = 1'b0;
        step_to(91); pll_locked = 1'b1;
        step_to(93); chk("s4_lost_t93", 32'(lost_lock_count), 32'(2));

        // Reset pulse during SDRAM hold
        step_to(110);
        chk("s5_hold_pll",   32'(pll_rst),   32'(0));
        chk("s5_hold_sdram", 32'(sdram_rst), 32'(1));
        do_reset(1);
        chk_reset_values("s5");
        step_to(3); chk("s5_pll_t3", 32'(pll_rst), 32'(1));
        step_to(4); chk("s5_pll_t4", 32'(pll_rst), 32'(0));

        // Two-cycle lock glitch in STABLE restarts the stable window
        step_to(6); pll_locked = 1'b0;
        step_to(8); pll_locked = 1'b1;
        step_to(9);  chk("s3_pll_t9",  32'(pll_rst), 32'(0));
        step_to(10); chk("s3_pll_t10", 32'(pll_rst), 32'(0));
        step_to(34); chk("s3_sdram_t34", 32'(sdram_rst), 32'(1));
        step_to(35); chk("s3_sdram_t35", 32'(sdram_rst), 32'(0));
        chk("s3_counts", 32'({retry_count, lost_lock_count}), 32'(0));
        step_to(43); chk("s3_ready_t43", 32'(ready), 32'(1));

        // Lock timeout with saturating retry count
        pll_locked = 1'b0;
        do_reset(2);
        for (int k = 1; k <= 17; k++) begin
            step_to(36 * k - 1);
            chk("s2_pll_before", 32'(pll_rst), 32'(0));
            step_to(36 * k);
            chk("s2_pll_rise", 32'(pll_rst), 32'(1));
            chk("s2_retry", 32'(retry_count), 32'((k < SAT) ? k : SAT));
            step_to(36 * k + 3);
            chk("s2_pll_hold", 32'(pll_rst), 32'(1));
            step_to(36 * k + 4);
            chk("s2_pll_fall", 32'(pll_rst), 32'(0));
            chk("s2_sdram", 32'(sdram_rst), 32'(1));
        end

        // Random lock toggling with occasional resets, model-checked every cycle
        do_reset(2);
        seg = 0;
        for (int i = 0; i < 10000; i++) begin
            if (seg == 0) begin
                pll_locked = ~pll_locked;
                seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 120))
                                                  : int'($urandom_range(1, 12));
            end
            seg--;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
